mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage, directly downstream of the EX/ALU stage.
- Consumes the ALU result, effective address and control bits; issues load/store requests to data memory over a req/gnt + rvalid handshake.
- Stalls upstream while a memory access is outstanding.
- Registers the write-back bundle (data, destination register, write enable) for the WB stage.

Parameters:
- DATA_W, 32, datapath and memory word width.
- ADDR_W, 32, data-memory byte-address width.
- TMO_CYCLES, 255, max cycles spent in REQ or WAIT before the access is abandoned with an error; 8-bit counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_2_mem  in  1  EX bundle valid.
- rd  in  DATA_W  ALU result.
- A  in  ADDR_W  load/store effective address.
- st_data_2_mem  in  DATA_W  store data (rt value).
- mem_read_2_mem  in  1  load.
- mem_write_2_mem  in  1  store.
- mem_to_reg_2_mem  in  1  write-back source: 1 = memory data, 0 = rd.
- reg_write_2_mem  in  1  instruction writes the register file.
- rd_add_value_2_mem  in  5  destination register index.
- stall_2_ex  out  1  upstream must hold its bundle stable.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_W  request address.
- dmem_wdata  out  DATA_W  store data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  DATA_W  load data.
- wb_valid  out  1  WB bundle valid.
- wb_reg_write  out  1  WB register-file write enable.
- wb_rd_add  out  5  WB destination index.
- wb_data  out  DATA_W  WB data.
- mem_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timeout counter 0. An asynchronous reset mid-access drops the access silently; no wb_valid is produced for it.
- FSM states: IDLE, REQ, WAIT.
- IDLE, bundle valid with neither mem_read_2_mem nor mem_write_2_mem:
  - Next edge: wb_valid=1, wb_data=rd, wb_reg_write=reg_write_2_mem, wb_rd_add=rd_add_value_2_mem.
  - Latency 1 cycle; stall_2_ex=0.
- IDLE, bundle valid with a load or store:
  - Capture A, st_data_2_mem, mem_read_2_mem, mem_to_reg_2_mem, reg_write_2_mem and rd_add_value_2_mem into holding registers; go to REQ.
  - stall_2_ex=1 combinationally in that cycle and for every cycle in REQ/WAIT.
- mem_read_2_mem and mem_write_2_mem both set: treated as a store; no register write-back.
- REQ:
  - dmem_req=1; dmem_we, dmem_addr and dmem_wdata driven from the holding registers and held stable until dmem_gnt.
  - On gnt: a store goes to IDLE and emits wb_valid=1 with wb_reg_write=0; a load goes to WAIT.
- WAIT, dmem_rvalid=1:
  - wb_data = mem_to_reg ? dmem_rdata : held rd; wb_reg_write=held reg_write; wb_valid=1; go to IDLE.
  - dmem_rvalid in the same cycle as gnt is not supported; rvalid is only sampled in WAIT.
- stall_2_ex is low in the cycle the FSM returns to IDLE; the next EX bundle is accepted on the following edge.
- Throughput: 1 instruction/cycle for non-memory ops. Loads take at least 3 cycles, stores at least 2.
- Timeout:
  - The counter clears on entry to REQ and on entry to WAIT, and increments in each of those states.
  - On reaching TMO_CYCLES: mem_err pulses, FSM goes to IDLE, and wb_valid=1 with wb_reg_write=0.
- wb_valid is a single-cycle pulse per instruction. wb_data, wb_rd_add and wb_reg_write hold their last values when wb_valid=0.
- An invalid bundle (valid_2_mem=0) produces wb_valid=0 and no memory activity.

Optional Feature:
- Macro: MEM_ALIGN_CHK_EN.
- Defined: a load/store with A[1:0]!=0 issues no request. mem_err pulses the cycle after capture, wb_valid=1 with wb_reg_write=0, and the FSM stays in IDLE; stall is 1 for that single capture cycle.
- Undefined: no alignment check; the address is passed through unmodified.

Decomposition:
- Shared package mem_pkg:
  - enum mem_state_e {IDLE, REQ, WAIT};
  - struct wb_bundle_t {valid, reg_write, rd_add[4:0], data};
  - localparam REG_ADDR_W=5.
- One sub-module: mem_tmo_cnt (clear/enable/terminal-count counter, parameter TMO_CYCLES).

Test Plan:
- ALU op: rd=0x0000_0005, reg_write=1, rd_add=3, no mem -> next cycle wb_valid=1, wb_data=5, wb_rd_add=3, stall never asserted.
- Load: A=0x100, mem_to_reg=1, rd_add=7; gnt after 2 cycles, rvalid=0xDEAD_BEEF 1 cycle later -> dmem_addr=0x100 stable in REQ; wb_data=0xDEADBEEF, wb_rd_add=7; stall high from the capture cycle through the WAIT cycle where rvalid arrives, low the cycle the FSM returns to IDLE.
- Store: A=0x204, st_data=0x1234, gnt in first REQ cycle -> dmem_we=1, dmem_wdata=0x1234, wb_valid=1 with wb_reg_write=0.
- Timeout: load with gnt never asserted, TMO_CYCLES=4 -> mem_err pulse after 4 REQ cycles, return to IDLE, wb_reg_write=0.
- Reset asserted (low) during WAIT -> all outputs 0 immediately, IDLE; a late rvalid after release is ignored.
- MEM_ALIGN_CHK_EN build: load at A=0x102 -> no dmem_req, mem_err pulse, wb_reg_write=0.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// mem_pkg : shared state encoding and write-back bundle for mem_stage
// Rev 1.0
// ============================================================================
package mem_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WB_DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd_add;
    logic [WB_DATA_W-1:0]  data;
  } wb_bundle_t;

endpackage
`default_nettype wire

// File: rtl/mem_tmo_cnt.sv
`default_nettype none
// ============================================================================
// mem_tmo_cnt : 8-bit clear/enable counter flagging the TMO_CYCLES-th cycle
// Rev 1.0
// ============================================================================
module mem_tmo_cnt #(
  parameter int TMO_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [7:0] TC_VAL = 8'(TMO_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Count is 0 in the first cycle of a state, so TMO_CYCLES-1 marks the last allowed cycle.
  assign tc = en && (cnt_q == TC_VAL);

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : MEM pipeline stage - dmem req/gnt/rvalid access, WB bundle register
// Optional build macro MEM_ALIGN_CHK_EN traps misaligned loads/stores.
// Rev 1.0
// ============================================================================
module mem_stage
  import mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int TMO_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_2_mem,
  input  logic [DATA_W-1:0]     rd,
  input  logic [ADDR_W-1:0]     A,
  input  logic [DATA_W-1:0]     st_data_2_mem,
  input  logic                  mem_read_2_mem,
  input  logic                  mem_write_2_mem,
  input  logic                  mem_to_reg_2_mem,
  input  logic                  reg_write_2_mem,
  input  logic [REG_ADDR_W-1:0] rd_add_value_2_mem,
  output logic                  stall_2_ex,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd_add,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  mem_err
);

  mem_state_e            state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdv_q, rdv_d;
  logic                  store_q, store_d;
  logic                  m2r_q, m2r_d;
  logic                  rw_q, rw_d;
  logic [REG_ADDR_W-1:0] rda_q, rda_d;
  wb_bundle_t            wb_q, wb_d;
  logic                  err_q, err_d;

  logic tmo_clr, tmo_en, tmo_tc;
  logic mem_op, misalign;

  assign mem_op = mem_read_2_mem | mem_write_2_mem;

`ifdef MEM_ALIGN_CHK_EN
  assign misalign = (A[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  mem_tmo_cnt #(.TMO_CYCLES(TMO_CYCLES)) u_tmo (
    .clk   (clk),
    .rst_n (reset),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .tc    (tmo_tc)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdv_d     = rdv_q;
    store_d   = store_q;
    m2r_d     = m2r_q;
    rw_d      = rw_q;
    rda_d     = rda_q;
    wb_d      = wb_q;
    wb_d.valid = 1'b0;
    err_d     = 1'b0;
    tmo_clr   = 1'b0;
    tmo_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_2_mem && !mem_op) begin
          wb_d.valid     = 1'b1;
          wb_d.reg_write = reg_write_2_mem;
          wb_d.rd_add    = rd_add_value_2_mem;
          wb_d.data      = WB_DATA_W'(rd);
        end else if (valid_2_mem && misalign) begin
          wb_d.valid     = 1'b1;
          wb_d.reg_write = 1'b0;
          err_d          = 1'b1;
        end else if (valid_2_mem) begin
          // Read+write together is a store: no register write-back.
          addr_d  = A;
          wdata_d = st_data_2_mem;
          rdv_d   = rd;
          store_d = mem_write_2_mem;
          m2r_d   = mem_to_reg_2_mem;
          rw_d    = reg_write_2_mem;
          rda_d   = rd_add_value_2_mem;
          tmo_clr = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        tmo_en = 1'b1;
        if (dmem_gnt) begin
          if (store_q) begin
            wb_d.valid     = 1'b1;
            wb_d.reg_write = 1'b0;
            state_d        = IDLE;
          end else begin
            tmo_clr = 1'b1;
            state_d = WAIT;
          end
        end else if (tmo_tc) begin
          wb_d.valid     = 1'b1;
          wb_d.reg_write = 1'b0;
          err_d          = 1'b1;
          state_d        = IDLE;
        end
      end
      WAIT: begin
        tmo_en = 1'b1;
        if (dmem_rvalid) begin
          wb_d.valid     = 1'b1;
          wb_d.reg_write = rw_q;
          wb_d.rd_add    = rda_q;
          wb_d.data      = m2r_q ? WB_DATA_W'(dmem_rdata) : WB_DATA_W'(rdv_q);
          state_d        = IDLE;
        end else if (tmo_tc) begin
          wb_d.valid     = 1'b1;
          wb_d.reg_write = 1'b0;
          err_d          = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdv_q   <= '0;
      store_q <= 1'b0;
      m2r_q   <= 1'b0;
      rw_q    <= 1'b0;
      rda_q   <= '0;
      wb_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdv_q   <= rdv_d;
      store_q <= store_d;
      m2r_q   <= m2r_d;
      rw_q    <= rw_d;
      rda_q   <= rda_d;
      wb_q    <= wb_d;
      err_q   <= err_d;
    end
  end

  // Stall covers the capture cycle and every REQ/WAIT cycle, dropping on return to IDLE.
  assign stall_2_ex   = (state_q != IDLE) || (valid_2_mem && mem_op);
  assign dmem_req     = (state_q == REQ);
  assign dmem_we      = (state_q == REQ) && store_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign wb_valid     = wb_q.valid;
  assign wb_reg_write = wb_q.reg_write;
  assign wb_rd_add    = wb_q.rd_add;
  assign wb_data      = DATA_W'(wb_q.data);
  assign mem_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// tb_mem_stage : randomized bench; expectations come from a per-transaction schedule model.
module tb_mem_stage;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_2_mem;
  logic [DW-1:0] rd;
  logic [AW-1:0] A;
  logic [DW-1:0] st_data_2_mem;
  logic          mem_read_2_mem, mem_write_2_mem, mem_to_reg_2_mem, reg_write_2_mem;
  logic [4:0]    rd_add_value_2_mem;
  logic          stall_2_ex, dmem_req, dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_gnt, dmem_rvalid;
  logic [DW-1:0] dmem_rdata;
  logic          wb_valid, wb_reg_write;
  logic [4:0]    wb_rd_add;
  logic [DW-1:0] wb_data;
  logic          mem_err;

  mem_stage #(.DATA_W(DW), .ADDR_W(AW), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .valid_2_mem(valid_2_mem), .rd(rd), .A(A),
    .st_data_2_mem(st_data_2_mem), .mem_read_2_mem(mem_read_2_mem),
    .mem_write_2_mem(mem_write_2_mem), .mem_to_reg_2_mem(mem_to_reg_2_mem),
    .reg_write_2_mem(reg_write_2_mem), .rd_add_value_2_mem(rd_add_value_2_mem),
    .stall_2_ex(stall_2_ex), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_rd_add(wb_rd_add), .wb_data(wb_data),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle.
  logic          e_stall, e_req, e_we, e_wbv, e_rw, e_err, e_known;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_data;
  logic [4:0]    e_rda;
  // Write-back state the model predicts after the coming edge (rw/rda/data hold).
  logic          p_wbv, p_err, p_rw, p_known;
  logic [4:0]    p_rda;
  logic [DW-1:0] p_data;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall_2_ex", 64'(stall_2_ex), 64'(e_stall));
      check("dmem_req", 64'(dmem_req), 64'(e_req));
      if (e_req) begin
        check("dmem_we", 64'(dmem_we), 64'(e_we));
        check("dmem_addr", 64'(dmem_addr), 64'(e_addr));
        check("dmem_wdata", 64'(dmem_wdata), 64'(e_wdata));
      end
      check("wb_valid", 64'(wb_valid), 64'(e_wbv));
      check("wb_reg_write", 64'(wb_reg_write), 64'(e_rw));
      check("mem_err", 64'(mem_err), 64'(e_err));
      if (e_known) begin
        check("wb_rd_add", 64'(wb_rd_add), 64'(e_rda));
        check("wb_data", 64'(wb_data), 64'(e_data));
      end
    end
  end

  task automatic model_reset();
    p_wbv = 0; p_err = 0; p_rw = 0; p_rda = '0; p_data = '0; p_known = 1;
    e_wbv = 0; e_err = 0; e_rw = 0; e_rda = '0; e_data = '0; e_known = 1;
    e_stall = 0; e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0;
  endtask

  // Every cycle task starts at posedge+2 and returns at the next posedge+2.
  task automatic begin_cycle();
    e_wbv = p_wbv; e_err = p_err; e_rw = p_rw; e_rda = p_rda; e_data = p_data; e_known = p_known;
    p_wbv = 0; p_err = 0;
    e_stall = 0; e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    dmem_gnt    = 1'($urandom_range(0, 1));
    dmem_rvalid = 1'($urandom_range(0, 1));
    dmem_rdata  = $urandom();
  endtask

  task automatic end_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic retire_nowrite(input logic err);
    p_wbv = 1; p_rw = 0; p_err = err; p_known = 0;
  endtask

  task automatic do_bubble();
    begin_cycle();
    valid_2_mem = 0; rd = $urandom(); A = $urandom(); st_data_2_mem = $urandom();
    mem_read_2_mem = 1'($urandom_range(0, 1)); mem_write_2_mem = 1'($urandom_range(0, 1));
    mem_to_reg_2_mem = 1'($urandom_range(0, 1)); reg_write_2_mem = 1'($urandom_range(0, 1));
    rd_add_value_2_mem = 5'($urandom());
    end_cycle();
  endtask

  task automatic do_alu(input logic [DW-1:0] r, input logic w, input logic [4:0] ra);
    begin_cycle();
    valid_2_mem = 1; rd = r; reg_write_2_mem = w; rd_add_value_2_mem = ra;
    mem_read_2_mem = 0; mem_write_2_mem = 0;
    mem_to_reg_2_mem = 1'($urandom_range(0, 1)); A = $urandom(); st_data_2_mem = $urandom();
    p_wbv = 1; p_rw = w; p_rda = ra; p_data = r; p_known = 1;
    end_cycle();
  endtask

  // gd: REQ cycles before gnt; rdl: WAIT cycles before rvalid (>= TMO means never).
  task automatic do_mem(input logic ld, input logic st, input logic [AW-1:0] a,
                        input logic [DW-1:0] sd, input logic [DW-1:0] r,
                        input logic [DW-1:0] rdat, input logic m2r, input logic w,
                        input logic [4:0] ra, input int gd, input int rdl);
    bit misal = 0;
    bit granted = 0;
`ifdef MEM_ALIGN_CHK_EN
    misal = (a[1:0] != 2'b00);
`endif
    begin_cycle();
    valid_2_mem = 1; rd = r; A = a; st_data_2_mem = sd; mem_read_2_mem = ld;
    mem_write_2_mem = st; mem_to_reg_2_mem = m2r; reg_write_2_mem = w; rd_add_value_2_mem = ra;
    e_stall = 1;
    if (misal) retire_nowrite(1'b1);
    end_cycle();
    if (misal) return;
    for (int i = 0; i < TMO; i++) begin
      begin_cycle();
      e_stall = 1; e_req = 1; e_we = st; e_addr = a; e_wdata = sd;
      dmem_gnt = (i == gd);
      if (i == gd) begin
        granted = 1;
        if (st) retire_nowrite(1'b0);
      end else if (i == TMO - 1) begin
        retire_nowrite(1'b1);
      end
      end_cycle();
      if (i == gd) break;
    end
    if (!granted || st) return;
    for (int j = 0; j < TMO; j++) begin
      begin_cycle();
      e_stall = 1;
      dmem_rvalid = (j == rdl);
      if (j == rdl) begin
        dmem_rdata = rdat;
        p_wbv = 1; p_rw = w; p_rda = ra; p_data = m2r ? rdat : r; p_known = 1;
      end else if (j == TMO - 1) begin
        retire_nowrite(1'b1);
      end
      end_cycle();
      if (j == rdl) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; valid_2_mem = 0; rd = '0; A = '0; st_data_2_mem = '0;
    mem_read_2_mem = 0; mem_write_2_mem = 0; mem_to_reg_2_mem = 0; reg_write_2_mem = 0;
    rd_add_value_2_mem = '0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
    model_reset();
    chk_en = 1;
    @(posedge clk); #2;
    check("reset wb_valid", 64'(wb_valid), 64'h0);
    check("reset mem_err", 64'(mem_err), 64'h0);
    check("reset dmem_req", 64'(dmem_req), 64'h0);
    check("reset wb_data", 64'(wb_data), 64'h0);
    @(posedge clk); #2;
    reset = 1;
    end_cycle();

    do_alu(32'h0000_0005, 1'b1, 5'd3);
    check("alu wb_valid", 64'(wb_valid), 64'h1);
    check("alu wb_data", 64'(wb_data), 64'h5);
    check("alu wb_rd_add", 64'(wb_rd_add), 64'h3);

    do_mem(1'b1, 1'b0, 32'h100, 32'hCAFE_0001, 32'h0000_0077, 32'hDEAD_BEEF,
           1'b1, 1'b1, 5'd7, 2, 1);
    check("load wb_data", 64'(wb_data), 64'hDEAD_BEEF);
    check("load wb_rd_add", 64'(wb_rd_add), 64'h7);
    check("load wb_reg_write", 64'(wb_reg_write), 64'h1);

    do_mem(1'b0, 1'b1, 32'h204, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 1'b1, 5'd9, 0, 0);
    check("store wb_valid", 64'(wb_valid), 64'h1);
    check("store wb_reg_write", 64'(wb_reg_write), 64'h0);

    do_mem(1'b1, 1'b0, 32'h400, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd4, 99, 0);
    check("req timeout mem_err", 64'(mem_err), 64'h1);
    check("req timeout wb_reg_write", 64'(wb_reg_write), 64'h0);
    do_bubble();
    check("mem_err pulse width", 64'(mem_err), 64'h0);

    do_mem(1'b1, 1'b0, 32'h408, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd5, 1, 99);
    do_mem(1'b1, 1'b1, 32'h40C, 32'h5A5A_5A5A, 32'h0, 32'h0, 1'b1, 1'b1, 5'd6, 1, 0);
    do_mem(1'b1, 1'b0, 32'h410, 32'h0, 32'hABCD_0000, 32'h1111_2222, 1'b0, 1'b1, 5'd8, 0, 0);
    check("load rd passthrough", 64'(wb_data), 64'hABCD_0000);

    // Asynchronous reset in WAIT: everything clears at once and the late rvalid is ignored.
    begin_cycle();
    valid_2_mem = 1; A = 32'h300; mem_read_2_mem = 1; mem_write_2_mem = 0;
    mem_to_reg_2_mem = 1; reg_write_2_mem = 1; rd_add_value_2_mem = 5'd2; e_stall = 1;
    end_cycle();
    begin_cycle();
    e_stall = 1; e_req = 1; e_we = 0; e_addr = 32'h300; e_wdata = st_data_2_mem; dmem_gnt = 1;
    end_cycle();
    begin_cycle();
    valid_2_mem = 0; dmem_gnt = 0; dmem_rvalid = 0; reset = 0;
    model_reset();
    #1;
    check("async reset stall", 64'(stall_2_ex), 64'h0);
    check("async reset wb_reg_write", 64'(wb_reg_write), 64'h0);
    end_cycle();
    begin_cycle();
    valid_2_mem = 0; reset = 1;
    end_cycle();
    begin_cycle();
    valid_2_mem = 0; dmem_rvalid = 1; dmem_rdata = 32'hBAD0_BAD0;
    end_cycle();
    check("late rvalid ignored", 64'(wb_valid), 64'h0);
    do_bubble();

`ifdef MEM_ALIGN_CHK_EN
    do_mem(1'b1, 1'b0, 32'h102, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd1, 0, 0);
    check("misalign mem_err", 64'(mem_err), 64'h1);
    check("misalign wb_reg_write", 64'(wb_reg_write), 64'h0);
`endif

    for (int t = 0; t < 300; t++) begin
      int kind;
      kind = $urandom_range(0, 99);
      if (kind < 40) begin
        do_alu($urandom(), 1'($urandom_range(0, 1)), 5'($urandom()));
      end else if (kind < 55) begin
        do_bubble();
      end else begin
        logic [AW-1:0] a;
        int op;
        a = $urandom();
        if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
        op = $urandom_range(0, 2);
        do_mem(op != 1, op != 0, a, $urandom(), $urandom(), $urandom(),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom()),
               $urandom_range(0, 5), $urandom_range(0, 5));
      end
    end
    do_bubble();
    do_bubble();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
